bus_device_port: RTL and testbench

- Device-side endpoint of the shared bus. The bus generator/arbiter pops packets from it and pushes packets into it.
- Holds a TX FIFO that feeds the bus through pndng/D_pop/pop.
- Holds an RX FIFO that accepts bus push/D_push, filtered by destination ID.
- Each of the drvrs bus slots is served by one instance; the local host side writes TX and reads RX.

---
 rtl/bus_device_port.sv | 156 +++++++++++++++
 tb/tb_bus_device_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_device_port.sv
// bus_device_port: device-side endpoint of the shared bus.
// The TX FIFO is written by the host and drained by the bus through pndng/D_pop/pop.
// The RX FIFO is filled by bus pushes whose destination ID matches, and drained by the host.
// Optional: define BUS_DEVICE_PORT_STATS_EN to build the sticky err_flags and the
// filt_cnt/drop_cnt counters. Without it, those outputs are tied to 0.
module bus_device_port #(
   parameter int unsigned pckg_sz   = 16,
   parameter logic [7:0]  id        = 8'd0,
   parameter logic [7:0]  broadcast = 8'hFF,
   parameter int unsigned depth     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   // bus side, TX
   output logic                       pndng,
   output logic [pckg_sz-1:0]         D_pop,
   input  logic                       pop,
   // bus side, RX
   input  logic                       push,
   input  logic [pckg_sz-1:0]         D_push,
   // host side, TX
   input  logic                       tx_wr,
   input  logic [pckg_sz-1:0]         tx_data,
   output logic                       tx_full,
   output logic [$clog2(depth):0]     tx_count,
   // host side, RX
   input  logic                       rx_rd,
   output logic [pckg_sz-1:0]         rx_data,
   output logic                       rx_valid,
   output logic [$clog2(depth):0]     rx_count,
   // statistics
   output logic [3:0]                 err_flags,
   output logic [7:0]                 filt_cnt,
   output logic [7:0]                 drop_cnt
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] CntFull = CW'(depth);

   // ---------------------------------------------------------------- TX FIFO
   logic [pckg_sz-1:0] tx_mem [depth];
   logic [AW-1:0]      tx_wr_ptr_q, tx_rd_ptr_q;
   logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
   logic               tx_empty, tx_is_full, tx_do_wr, tx_do_pop;

   // TX handshake decode; a write into a full FIFO is allowed when the bus pops in the same cycle
   always_comb begin
      tx_empty   = (tx_cnt_q == '0);
      tx_is_full = (tx_cnt_q == CntFull);
      tx_do_pop  = pop & ~tx_empty;
      tx_do_wr   = tx_wr & (~tx_is_full | pop);
      tx_cnt_d   = tx_cnt_q + {{(CW-1){1'b0}}, tx_do_wr} - {{(CW-1){1'b0}}, tx_do_pop};
   end

   // TX storage; contents need no reset since the count gates visibility
   always_ff @(posedge clk) begin
      if (tx_do_wr) tx_mem[tx_wr_ptr_q] <= tx_data;
   end

   // TX pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_cnt_q    <= '0;
      end else begin
         if (tx_do_wr)  tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
         if (tx_do_pop) tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
         tx_cnt_q <= tx_cnt_d;
      end
   end

   assign pndng    = ~tx_empty;
   assign D_pop    = tx_empty ? '0 : tx_mem[tx_rd_ptr_q];
   assign tx_full  = tx_is_full;
   assign tx_count = tx_cnt_q;

   // ---------------------------------------------------------------- RX FIFO
   logic [pckg_sz-1:0] rx_mem [depth];
   logic [AW-1:0]      rx_wr_ptr_q, rx_rd_ptr_q;
   logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
   logic [7:0]         rx_dest;
   logic               rx_match, rx_empty, rx_is_full, rx_do_wr, rx_do_rd;

   // RX ID filter and handshake decode; the bus is never stalled
   always_comb begin
      rx_dest    = D_push[pckg_sz-1 -: 8];
      rx_match   = (rx_dest == id) || (rx_dest == broadcast);
      rx_empty   = (rx_cnt_q == '0);
      rx_is_full = (rx_cnt_q == CntFull);
      rx_do_rd   = rx_rd & ~rx_empty;
      rx_do_wr   = push & rx_match & (~rx_is_full | rx_rd);
      rx_cnt_d   = rx_cnt_q + {{(CW-1){1'b0}}, rx_do_wr} - {{(CW-1){1'b0}}, rx_do_rd};
   end

   // RX storage
   always_ff @(posedge clk) begin
      if (rx_do_wr) rx_mem[rx_wr_ptr_q] <= D_push;
   end

   // RX pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_cnt_q    <= '0;
      end else begin
         if (rx_do_wr) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
         if (rx_do_rd) rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
         rx_cnt_q <= rx_cnt_d;
      end
   end

   assign rx_valid = ~rx_empty;
   assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];
   assign rx_count = rx_cnt_q;

   // ---------------------------------------------------------------- statistics
`ifdef BUS_DEVICE_PORT_STATS_EN
   logic [3:0] err_q;
   logic [7:0] filt_q, drop_q;
   logic       ev_tx_ovf, ev_tx_udf, ev_rx_drop, ev_rx_udf, ev_filt;

   // error and counter events
   always_comb begin
      ev_tx_ovf  = tx_wr & tx_is_full & ~pop;
      ev_tx_udf  = pop & tx_empty;
      ev_rx_drop = push & rx_match & rx_is_full & ~rx_rd;
      ev_rx_udf  = rx_rd & rx_empty;
      ev_filt    = push & ~rx_match;
   end

   // sticky flags and saturating counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q  <= '0;
         filt_q <= '0;
         drop_q <= '0;
      end else begin
         err_q <= err_q | {ev_rx_udf, ev_rx_drop, ev_tx_udf, ev_tx_ovf};
         if (ev_filt && (filt_q != 8'hFF))    filt_q <= filt_q + 8'd1;
         if (ev_rx_drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
   end

   assign err_flags = err_q;
   assign filt_cnt  = filt_q;
   assign drop_cnt  = drop_q;
`else
   assign err_flags = '0;
   assign filt_cnt  = '0;
   assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_bus_device_port.sv
// Scoreboard bench for bus_device_port (id=3, depth=8, 16-bit packets).
// Expected bus pops and host reads are queued at stimulus time; a negedge monitor
// pops and compares whenever a transfer is presented.
module tb_bus_device_port;

`ifdef BUS_DEVICE_PORT_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   logic        clk, reset;
   logic        pndng, pop, push, tx_wr, tx_full, rx_rd, rx_valid;
   logic [15:0] d_pop, d_push, tx_data, rx_data;
   logic [3:0]  tx_count, rx_count, err_flags;
   logic [7:0]  filt_cnt, drop_cnt;

   logic [15:0] tx_exp[$];
   logic [15:0] rx_exp[$];
   logic [15:0] mon_tx_e, mon_rx_e;
   int          n_total = 0;
   int          n_pass  = 0;

   bus_device_port #(
      .pckg_sz   (16),
      .id        (8'd3),
      .broadcast (8'hFF),
      .depth     (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pndng     (pndng),
      .D_pop     (d_pop),
      .pop       (pop),
      .push      (push),
      .D_push    (d_push),
      .tx_wr     (tx_wr),
      .tx_data   (tx_data),
      .tx_full   (tx_full),
      .tx_count  (tx_count),
      .rx_rd     (rx_rd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_count  (rx_count),
      .err_flags (err_flags),
      .filt_cnt  (filt_cnt),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // statistics outputs read 0 when the stats build option is off
   function automatic logic [31:0] st(input logic [31:0] v);
      return Stats ? v : 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: compare every transfer the DUT presents against the scoreboard
   always @(negedge clk) begin
      if (reset && pop && pndng) begin
         if (tx_exp.size() == 0) begin
            n_total++;
            $display("FAIL tx_pop_unexpected: got %0h, expected no pop data", d_pop);
         end else begin
            mon_tx_e = tx_exp.pop_front();
            chk("tx_pop_data", {16'd0, d_pop}, {16'd0, mon_tx_e});
         end
      end
      if (reset && rx_rd && rx_valid) begin
         if (rx_exp.size() == 0) begin
            n_total++;
            $display("FAIL rx_rd_unexpected: got %0h, expected no rx data", rx_data);
         end else begin
            mon_rx_e = rx_exp.pop_front();
            chk("rx_rd_data", {16'd0, rx_data}, {16'd0, mon_rx_e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; pop = 1'b0; push = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0;
      d_push = '0; tx_data = '0;
      tick(); tick();
      chk("rst_pndng",    pndng,     0);
      chk("rst_tx_full",  tx_full,   0);
      chk("rst_rx_valid", rx_valid,  0);
      chk("rst_tx_count", tx_count,  0);
      chk("rst_rx_count", rx_count,  0);
      chk("rst_err",      err_flags, 0);
      chk("rst_d_pop",    d_pop,     0);
      chk("rst_rx_data",  rx_data,   0);
      reset = 1'b1;
      tick();

      // basic TX ordering and write-to-pndng latency
      tx_wr = 1'b1; tx_data = 16'h0101; tx_exp.push_back(16'h0101);
      tick();
      chk("t1_pndng_lat", pndng, 1);
      chk("t1_d_pop_head", d_pop, 16'h0101);
      tx_data = 16'h0202; tx_exp.push_back(16'h0202); tick();
      tx_data = 16'h0303; tx_exp.push_back(16'h0303); tick();
      tx_wr = 1'b0;
      chk("t1_tx_count3", tx_count, 3);
      pop = 1'b1;
      repeat (3) tick();
      pop = 1'b0;
      chk("t1_pndng_done", pndng, 0);
      chk("t1_tx_count0", tx_count, 0);

      // TX full, overflow, write-with-pop at full
      tx_wr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tx_data = 16'h1000 + 16'(i); tx_exp.push_back(tx_data); tick();
      end
      chk("t2_tx_full", tx_full, 1);
      chk("t2_tx_count8", tx_count, 8);
      tx_data = 16'hDEAD; tick();
      chk("t2_ovf_err", err_flags, st(4'b0001));
      chk("t2_ovf_count", tx_count, 8);
      tx_data = 16'hBEEF; pop = 1'b1; tx_exp.push_back(16'hBEEF); tick();
      tx_wr = 1'b0;
      chk("t2_wrpop_count", tx_count, 8);
      repeat (8) tick();
      pop = 1'b0;
      chk("t2_drained", pndng, 0);

      // RX ID filter
      push = 1'b1;
      d_push = 16'h03AA; rx_exp.push_back(16'h03AA); tick();
      d_push = 16'hFF55; rx_exp.push_back(16'hFF55); tick();
      d_push = 16'h0711; tick();
      push = 1'b0;
      chk("t3_rx_count2", rx_count, 2);
      chk("t3_rx_head", rx_data, 16'h03AA);
      chk("t3_filt", filt_cnt, st(1));
      rx_rd = 1'b1;
      repeat (2) tick();
      rx_rd = 1'b0;
      chk("t3_rx_empty", rx_valid, 0);

      // RX full, drop, push-with-read at full
      push = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d_push = 16'h0300 + 16'(i); rx_exp.push_back(d_push); tick();
      end
      chk("t4_rx_count8", rx_count, 8);
      d_push = 16'h0377; tick();
      chk("t4_drop", drop_cnt, st(1));
      chk("t4_err", err_flags, st(4'b0101));
      chk("t4_drop_count", rx_count, 8);
      d_push = 16'h0388; rx_rd = 1'b1; rx_exp.push_back(16'h0388); tick();
      push = 1'b0;
      chk("t4_pushrd_count", rx_count, 8);
      repeat (8) tick();
      rx_rd = 1'b0;
      chk("t4_rx_count0", rx_count, 0);

      // underflow errors from a fresh reset
      reset = 1'b0; tx_exp.delete(); rx_exp.delete();
      tick();
      reset = 1'b1;
      tick();
      pop = 1'b1; rx_rd = 1'b1; tick();
      pop = 1'b0;
      chk("t5_udf_err", err_flags, st(4'b1010));
      chk("t5_tx_count", tx_count, 0);
      chk("t5_rx_count", rx_count, 0);
      push = 1'b1; d_push = 16'h03CC; rx_exp.push_back(16'h03CC); tick();
      push = 1'b0;
      chk("t5_push_on_empty_rd", rx_count, 1);
      tick();
      rx_rd = 1'b0;
      chk("t5_rx_count0", rx_count, 0);

      // asynchronous reset mid-stream
      tx_wr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tx_data = 16'h5000 + 16'(i); tick();
      end
      tx_wr = 1'b0;
      chk("t5_tx_count5", tx_count, 5);
      #3 reset = 1'b0;
      #1;
      chk("t5_async_pndng", pndng, 0);
      chk("t5_async_count", tx_count, 0);
      chk("t5_async_err", err_flags, 0);
      chk("t5_async_d_pop", d_pop, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("t5_post_rst_pndng", pndng, 0);

      // filter counter saturation
      push = 1'b1; d_push = 16'h0500;
      repeat (300) tick();
      push = 1'b0;
      chk("t6_filt_sat", filt_cnt, st(255));
      chk("t6_rx_count0", rx_count, 0);

      tick();
      chk("sb_tx_empty", tx_exp.size(), 0);
      chk("sb_rx_empty", rx_exp.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
